hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and data-memory wait stalls, branch flushes.
// Optional build macro HAZARD_PERF_EN adds a 32-bit StallCount port counting cycles with StallF=1.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemTimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount
`endif
);

  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       lw_stall;
  logic       mem_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // The M stage holds the younger result, so it wins over W when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)
      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign fwd_b = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = ((state == RUN) && MemReqM && !MemReadyM) ||
                     ((state == MWAIT) && !MemReadyM);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mem_stall) begin
        // Freeze the whole front of the pipe; W gets bubbles so nothing retires twice.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= 4'd0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= 4'd0;
          if (MemReqM && !MemReadyM)
            state <= MWAIT;
        end
        MWAIT: begin
          if (wait_cnt == 4'd15)
            MemTimeout <= 1'b1;
          if (MemReadyM) begin
            state    <= RUN;
            wait_cnt <= 4'd0;
          end else if (wait_cnt != 4'd15) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      StallCount <= 32'd0;
    else if (StallF)
      StallCount <= StallCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational vectors plus memory-wait, timeout and reset sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW, MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_EN
    , .StallCount(StallCount)
`endif
  );

  // Output bundle: {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [10:0] outs;
  assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  typedef struct packed {
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        rwm, rww;
    logic [1:0]  rsrc;
    logic        pcsrc;
    logic [10:0] exp_out;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // Move to just after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    //            rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pc  expected
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 2'b00, 0, 11'b10_00_0000_000};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 2'b00, 0, 11'b01_00_0000_000};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 2'b00, 0, 11'b01_00_0000_000};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd9, 5'd9, 1, 1, 2'b00, 0, 11'b00_10_0000_000};
    vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd3, 5'd9, 1, 1, 2'b00, 0, 11'b10_01_0000_000};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 2'b00, 0, 11'b00_00_0000_000};
    vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b01, 0, 11'b00_00_1100_010};
    vecs[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b01, 0, 11'b00_00_1100_010};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b01, 0, 11'b00_00_0000_000};
    vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b00, 0, 11'b00_00_0000_000};
    vecs[10] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b10, 0, 11'b00_00_0000_000};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 1, 11'b00_00_0000_110};
    vecs[12] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b01, 1, 11'b00_00_1100_110};

    // Reset dominates: every hazard source active, all outputs must stay low.
    next_cycle();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
    sample();
    check("reset_outputs", 32'(outs), 32'd0);
    next_cycle();
    sample();
    check("reset_timeout", 32'(MemTimeout), 32'd0);
    next_cycle();
    idle();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      next_cycle();
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc;
      sample();
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp_out));
    end

    // Load-use stall lasts only while the hazard is present.
    next_cycle();
    idle();
    sample();
    check("lw_release", 32'(outs), 32'd0);

    // Three-cycle memory wait with a branch and load hazard that must be ignored.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
      ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
      sample();
      check($sformatf("memwait_c%0d", c), 32'(outs), 32'(11'b00_00_1111_001));
    end
    next_cycle();
    idle();
    MemReqM = 1; MemReadyM = 1; PCSrcE = 1;
    sample();
    check("memwait_ready", 32'(outs), 32'(11'b00_00_0000_110));
    next_cycle();
    idle();
    sample();
    check("memwait_back_run", 32'(outs), 32'd0);

    // Request satisfied in the same cycle: no stall, FSM stays in RUN.
    next_cycle();
    MemReqM = 1; MemReadyM = 1;
    sample();
    check("same_cycle_ready", 32'(outs), 32'd0);
    next_cycle();
    idle();
    sample();
    check("same_cycle_run", 32'(outs), 32'd0);

    // Two 12-cycle waits: counter must clear between them, so no timeout.
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 12; c++) begin
        next_cycle();
        MemReqM = 1; MemReadyM = 0;
      end
      next_cycle();
      MemReadyM = 1;
    end
    next_cycle();
    idle();
    sample();
    check("cnt_cleared_no_timeout", 32'(MemTimeout), 32'd0);

    // Long wait: counter reaches 15 during stall cycle 17, flag visible from cycle 18.
    begin
      int stalled = 0;
      for (int c = 1; c <= 20; c++) begin
        next_cycle();
        MemReqM = 1; MemReadyM = 0;
        sample();
        if (StallF && StallM && FlushW) stalled++;
        if (c == 15) check("timeout_early", 32'(MemTimeout), 32'd0);
        if (c == 18) check("timeout_set", 32'(MemTimeout), 32'd1);
      end
      check("timeout_all_stalled", 32'(stalled), 32'd20);
    end
    next_cycle();
    MemReqM = 0;
    sample();
    check("timeout_sticky", 32'(MemTimeout), 32'd1);

    // Reset during MWAIT abandons the wait and clears the flag.
    next_cycle();
    reset = 1'b1;
    sample();
    check("reset_in_wait_outs", 32'(outs), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();
    sample();
    check("post_reset_timeout", 32'(MemTimeout), 32'd0);
    check("post_reset_run", 32'(outs), 32'd0);

`ifdef HAZARD_PERF_EN
    do_reset();
    idle();
    for (int l = 0; l < 3; l++) begin
      next_cycle();
      ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
      next_cycle();
      idle();
    end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      MemReqM = 1; MemReadyM = 0;
    end
    next_cycle();
    MemReadyM = 1;
    next_cycle();
    idle();
    sample();
    check("stall_count", StallCount, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
